// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared channel count and annunciator channel state encoding
package rpsc_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    ACKED    = 2'd2,
    RINGBACK = 2'd3
  } ch_state_t;

endpackage

// File: rtl/rpsc_ann_channel.sv
// rtl/rpsc_ann_channel.sv - one annunciator channel FSM; RINGBACK path built only with RPSC_RINGBACK_EN
module rpsc_ann_channel
  import rpsc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      la,
  input  logic      ack_p,
  input  logic      clear_p,
  output ch_state_t state,
  output logic      enter_alert
);

  assign enter_alert = (state == IDLE) && la;

`ifndef RPSC_RINGBACK_EN
  // Without ringback the operator reset only matters to the first-out register.
  logic unused_clear;
  assign unused_clear = clear_p;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (la) state <= ALERT;
        ALERT:    if (ack_p) state <= la ? ACKED : IDLE;
`ifdef RPSC_RINGBACK_EN
        ACKED:    if (!la) state <= RINGBACK;
        RINGBACK: begin
          if (la) state <= ALERT;
          else if (clear_p) state <= IDLE;
        end
`else
        ACKED:    if (!la) state <= IDLE;
`endif
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rpsc_lamp_sequencer.sv
// rtl/rpsc_lamp_sequencer.sv - annunciator lamp/horn sequencer with first-out; RPSC_RINGBACK_EN enables ringback
module rpsc_lamp_sequencer
  import rpsc_pkg::*;
#(
  parameter int FLASH_DIV = 25000000,
  parameter int NUM_CH    = rpsc_pkg::NUM_CH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_la,
  input  logic              i_ack,
  input  logic              i_clear,
  input  logic              i_lamptest,
  output logic [NUM_CH-1:0] o_lamp,
  output logic              o_horn,
  output logic              o_first_valid,
  output logic [2:0]        o_first_idx
);

  localparam int CW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;

  logic [NUM_CH-1:0] la_s1, la_s2;
  logic ack_s1, ack_s2, ack_q;
  logic clear_s1, clear_s2, clear_q;
  logic lt_s1, lt_s2;
  logic ack_p, clear_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      la_s1    <= '0;
      la_s2    <= '0;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_q    <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
      clear_q  <= 1'b0;
      lt_s1    <= 1'b0;
      lt_s2    <= 1'b0;
    end else begin
      la_s1    <= i_la;
      la_s2    <= la_s1;
      ack_s1   <= i_ack;
      ack_s2   <= ack_s1;
      ack_q    <= ack_s2;
      clear_s1 <= i_clear;
      clear_s2 <= clear_s1;
      clear_q  <= clear_s2;
      lt_s1    <= i_lamptest;
      lt_s2    <= lt_s1;
    end
  end

  assign ack_p   = ack_s2 & ~ack_q;
  assign clear_p = clear_s2 & ~clear_q;

  // Slow phase advances once per four fast-phase toggles.
  logic [CW-1:0] flash_cnt;
  logic [1:0]    fast_toggles;
  logic          fast_ph, slow_ph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt    <= '0;
      fast_toggles <= '0;
      fast_ph      <= 1'b0;
      slow_ph      <= 1'b0;
    end else if (flash_cnt == CW'(FLASH_DIV - 1)) begin
      flash_cnt    <= '0;
      fast_ph      <= ~fast_ph;
      fast_toggles <= fast_toggles + 2'd1;
      if (fast_toggles == 2'd3) slow_ph <= ~slow_ph;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  ch_state_t         state [NUM_CH];
  logic [NUM_CH-1:0] enter_alert, in_alert, lamp_next;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    rpsc_ann_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .la          (la_s2[n]),
      .ack_p       (ack_p),
      .clear_p     (clear_p),
      .state       (state[n]),
      .enter_alert (enter_alert[n])
    );
    assign in_alert[n]  = (state[n] == ALERT);
    assign lamp_next[n] = ((state[n] == ALERT) & fast_ph) | (state[n] == ACKED) |
                          ((state[n] == RINGBACK) & slow_ph);
  end

  logic [2:0] first_next;
  logic       first_release;

  always_comb begin
    first_next = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (enter_alert[n]) first_next = 3'(n);
    end
  end

  assign first_release = clear_p & ~(|in_alert);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lamp        <= '0;
      o_horn        <= 1'b0;
      o_first_valid <= 1'b0;
      o_first_idx   <= '0;
    end else begin
      o_lamp <= lt_s2 ? '1 : lamp_next;
      o_horn <= |in_alert;
      if (first_release) begin
        o_first_valid <= 1'b0;
        o_first_idx   <= '0;
      end
      // A release and a fresh entry in the same cycle re-arm straight to the new channel.
      if ((!o_first_valid || first_release) && (|enter_alert)) begin
        o_first_valid <= 1'b1;
        o_first_idx   <= first_next;
      end
    end
  end

endmodule

// File: doc/rpsc_lamp_sequencer.md
RPSC_LAMP_SEQUENCER -- requirements
Module: rpsc_lamp_sequencer

Interface
REQ-001 Parameter FLASH_DIV, default 25000000, clk cycles per fast-flash half-period; SHALL be >=2.
REQ-002 Parameter NUM_CH, default 8, number of annunciator channels; SHALL be taken from the shared package.
REQ-003 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_la  in  NUM_CH  latched-alarm inputs from the fault card (bit n = FFn+1_LA), asynchronous to clk.
REQ-006 i_ack  in  1  operator acknowledge pushbutton, asynchronous level.
REQ-007 i_clear  in  1  operator reset pushbutton, asynchronous level.
REQ-008 i_lamptest  in  1  lamp test switch, asynchronous level.
REQ-009 o_lamp  out  NUM_CH  lamp drive, 1 = lit.
REQ-010 o_horn  out  1  audible alarm drive.
REQ-011 o_first_valid  out  1  a first-out channel is held.
REQ-012 o_first_idx  out  3  index of the first-out channel.

Function
REQ-013 All asynchronous inputs SHALL pass a 2-flop synchronizer; i_ack and i_clear SHALL then be rising-edge detected (one-cycle pulses ack_p, clear_p).
REQ-014 Each channel SHALL run an FSM with states IDLE, ALERT, ACKED, RINGBACK, evaluated on synchronized la[n].
REQ-015 IDLE -> ALERT when la=1.
REQ-016 ALERT holds regardless of la (lock-in); on ack_p: -> ACKED if la=1, -> IDLE if la=0.
REQ-017 ACKED -> RINGBACK when la=0 (macro defined, REQ-030).
REQ-018 RINGBACK -> ALERT when la=1; RINGBACK -> IDLE on clear_p with la=0.
REQ-019 clear_p SHALL have no effect on IDLE, ALERT or ACKED channels.
REQ-020 Lamp per state: IDLE off, ALERT fast-flash phase, ACKED steady on, RINGBACK slow-flash phase; o_lamp SHALL be registered, one cycle after the state.
REQ-021 Flash counter SHALL count 0..FLASH_DIV-1 and wrap; fast phase toggles on each wrap; slow phase toggles on every 4th fast toggle; both phases SHALL be 0 out of reset.
REQ-022 o_horn SHALL be 1, registered, while any channel is in ALERT.
REQ-023 i_lamptest (synchronized) SHALL force o_lamp to all ones without changing any FSM state, the flash counter, o_horn or first-out.
REQ-024 First-out: when o_first_valid=0 and one or more channels enter ALERT from IDLE in the same cycle, SHALL capture the lowest such index and set o_first_valid=1; later entries SHALL NOT overwrite it.
REQ-025 First-out SHALL be cleared on clear_p only when no channel is in ALERT; otherwise clear_p leaves it held.
REQ-026 ack_p and clear_p in the same cycle: each channel SHALL apply only the rule for its current state (REQ-016/018); no other precedence applies.
REQ-027 An la rising edge in the same cycle as ack_p SHALL send that IDLE channel to ALERT, unaffected by the ack.

Reset
REQ-028 While reset=1: all channels IDLE, o_lamp=0, o_horn=0, o_first_valid=0, o_first_idx=0, flash counter and phases 0, synchronizers and edge detectors 0.
REQ-029 Reset asserted mid-sequence SHALL abandon all states immediately; after release, channels with la=1 SHALL re-enter ALERT after the synchronizer latency.

Configuration
REQ-030 With RPSC_RINGBACK_EN defined: REQ-017/018 as written. Without it: the RINGBACK state SHALL not exist; ACKED -> IDLE directly when la=0, and clear_p affects first-out only.

Structure
REQ-031 Package rpsc_pkg SHALL hold NUM_CH=8 and the channel state enum (IDLE, ALERT, ACKED, RINGBACK).
REQ-032 Per-channel FSM SHALL be sub-module rpsc_ann_channel, instantiated NUM_CH times; flash timing, synchronizers, horn and first-out SHALL live in the top.

Verification (FLASH_DIV=4, RPSC_RINGBACK_EN defined unless stated)
REQ-033 i_la[2]=1 -> ch2 ALERT; o_lamp[2] toggles every 4 cycles; o_horn=1; o_first_valid=1, o_first_idx=2.
REQ-034 Then i_la[5]=1, ack pulse -> ch2, ch5 ACKED, lamps steady 1, o_horn=0, o_first_idx stays 2.
REQ-035 Drop i_la[2] -> ch2 RINGBACK, toggles every 16 cycles; clear pulse -> ch2 off, o_first_valid=0.
REQ-036 i_la[3], i_la[6] rise in the same cycle -> o_first_idx=3; ack pulse in the same cycle as i_la[1] rising -> ch1 ALERT, o_horn stays 1.
REQ-037 i_lamptest=1 with ch4 in ALERT -> o_lamp=8'hFF, o_horn=1; release -> ch4 flash phase continues uninterrupted.
REQ-038 Macro undefined: ch0 ACKED, i_la[0] falls -> o_lamp[0]=0 with no clear needed; reset mid-ALERT -> all outputs 0 next edge.
